block_data_memory: RTL and testbench

Word-block data memory that answers the data cache's refill and write-back requests. It holds 64 blocks of 32 bits (256 bytes) and serves one whole block per access after a programmable latency. It holds `busywait` high for the whole access and drops it for exactly one cycle to complete the handshake. It sits between the data cache's memory-side port and the testbench/top level, and it is the responder end of the cache's `mem_*` interface.

---
 rtl/block_data_memory.sv | 137 +++++++++++++
 tb/tb_block_data_memory.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// 64 x 32-bit block memory answering cache refill / write-back requests
// with a programmable access latency and a one-cycle busywait release.
module block_data_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 8;
  localparam int unsigned NW    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          op_wr_q, op_wr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [NW-1:0] rd_cnt_q, rd_cnt_d;
  logic [NW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic accept_c;
  logic finish_c;
  logic mem_we_c;

  assign accept_c = (state_q == S_IDLE) && (read || write);
  assign finish_c = (state_q == S_BUSY) && (cnt_q == CW'(1));
  assign mem_we_c = finish_c && op_wr_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_c) state_d = S_BUSY;
      S_BUSY:  if (finish_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Busywait is combinational so a fresh request is seen busy immediately
  always_comb begin
    busywait = 1'b0;
    unique case (state_q)
      S_IDLE:  busywait = read | write;
      S_BUSY:  busywait = 1'b1;
      S_DONE:  busywait = 1'b0;
      default: busywait = 1'b0;
    endcase
    if (!reset) busywait = 1'b0;
  end

  // Request latch, latency countdown, completion side effects
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_wr_d  = op_wr_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept_c) begin
      cnt_d   = CW'(LATENCY);
      addr_d  = address;
      wdata_d = writedata;
      op_wr_d = write;
    end else if (state_q == S_BUSY && !finish_c) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (finish_c) begin
      if (op_wr_q) begin
        wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + NW'(1);
      end else begin
        rdata_d  = mem_q[addr_q];
        rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_wr_q  <= op_wr_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage array, cleared on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign readdata    = rdata_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: handshake timing, data, counters,
// reset behaviour, LATENCY=1 corner and counter saturation.
module tb_block_data_memory;

  localparam int unsigned LAT = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic [15:0] read_count, write_count;

  logic        r1, w1;
  logic [5:0]  a1;
  logic [31:0] d1;
  logic [31:0] rd1;
  logic        bw1;
  logic [15:0] rc1, wc1;

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clock = ~clock;

  block_data_memory #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .read_count(read_count), .write_count(write_count)
  );

  block_data_memory #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .read(r1), .write(w1),
    .address(a1), .writedata(d1), .readdata(rd1),
    .busywait(bw1), .read_count(rc1), .write_count(wc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
    read = r; write = w; address = a; writedata = d;
    #1 chk("busy_on_request", 32'(busywait), 32'd1);
  endtask

  // Count edges until busywait drops (bounded)
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
    end while (busywait && edges < 40);
  endtask

  task automatic idle_after();
    read = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_done", 32'(busywait), 32'd0);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    int e;
    req(1'b0, 1'b1, a, d);
    wait_done(e);
    chk("write_latency", 32'(e), 32'(LAT + 1));
    exp_wr = (exp_wr == 16'hFFFF) ? exp_wr : exp_wr + 1;
    chk("write_count", 32'(write_count), 32'(exp_wr));
    idle_after();
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] exp);
    int e;
    req(1'b1, 1'b0, a, 32'h0);
    wait_done(e);
    chk("read_latency", 32'(e), 32'(LAT + 1));
    chk("readdata_at_done", readdata, exp);
    exp_rd++;
    exp_rdata = exp;
    chk("read_count", 32'(read_count), 32'(exp_rd));
    idle_after();
  endtask

  task automatic do_reset();
    read = 1'b0; write = 1'b0;
    r1 = 1'b0; w1 = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_rdata = '0;
    @(posedge clock); #1;
  endtask

  initial begin
    int e;
    reset = 1'b0; read = 1'b1; write = 1'b0; address = 6'h15; writedata = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;

    // Reset held with a read pending
    #2;
    chk("rst_busywait", 32'(busywait), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busywait_edges", 32'(busywait), 32'd0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_read_count", 32'(read_count), 32'd0);
    chk("rst_write_count", 32'(write_count), 32'd0);
    read = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    do_read(6'h15, 32'h0000_0000);

    // Write then read
    do_write(6'h2A, 32'hDEAD_BEEF);
    do_read(6'h2A, 32'hDEAD_BEEF);

    // Field changes during BUSY are ignored
    req(1'b0, 1'b1, 6'h03, 32'h1234_5678);
    @(posedge clock); #1;
    address = 6'h04; writedata = 32'hFFFF_FFFF;
    wait_done(e);
    chk("stab_latency", 32'(e), 32'(LAT));
    exp_wr++;
    idle_after();
    do_read(6'h03, 32'h1234_5678);
    do_read(6'h04, 32'h0000_0000);
    chk("stab_write_count", 32'(write_count), 32'(exp_wr));

    // Write-back immediately followed by refill
    do_reset();
    req(1'b0, 1'b1, 6'h09, 32'hAAAA_5555);
    wait_done(e);
    chk("b2b_wb_latency", 32'(e), 32'(LAT + 1));
    read = 1'b1; write = 1'b0; address = 6'h11;
    @(posedge clock); #1;
    chk("b2b_no_gap", 32'(busywait), 32'd1);
    wait_done(e);
    chk("b2b_refill_latency", 32'(e), 32'(LAT + 1));
    chk("b2b_refill_data", readdata, 32'h0);
    idle_after();
    chk("b2b_write_count", 32'(write_count), 32'd1);
    chk("b2b_read_count", 32'(read_count), 32'd1);
    exp_wr = 1; exp_rd = 1;
    do_read(6'h09, 32'hAAAA_5555);

    // Reset in the middle of a write
    req(1'b0, 1'b1, 6'h3F, 32'hCAFE_F00D);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1 chk("midrst_busywait", 32'(busywait), 32'd0);
    write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_rdata = '0;
    repeat (LAT + 2) @(posedge clock);
    #1;
    chk("midrst_write_count", 32'(write_count), 32'd0);
    do_read(6'h3F, 32'h0000_0000);

    // read and write together act as a write
    do_read(6'h2A, 32'h0000_0000);
    req(1'b1, 1'b1, 6'h00, 32'h0BAD_F00D);
    wait_done(e);
    exp_wr++;
    chk("both_write_count", 32'(write_count), 32'(exp_wr));
    chk("both_read_count", 32'(read_count), 32'(exp_rd));
    chk("both_readdata_held", readdata, exp_rdata);
    idle_after();
    do_read(6'h00, 32'h0BAD_F00D);

    // LATENCY = 1 instance
    w1 = 1'b1; a1 = 6'h07; d1 = 32'h5A5A_0001;
    #1 chk("l1_busy_req", 32'(bw1), 32'd1);
    @(posedge clock); #1;
    chk("l1_busy_e0", 32'(bw1), 32'd1);
    @(posedge clock); #1;
    chk("l1_done_e1", 32'(bw1), 32'd0);
    chk("l1_write_count", 32'(wc1), 32'd1);
    w1 = 1'b0; r1 = 1'b1;
    @(posedge clock); #1;
    chk("l1_idle_new_req", 32'(bw1), 32'd1);
    @(posedge clock); #1;
    chk("l1_busy_accept", 32'(bw1), 32'd1);
    @(posedge clock); #1;
    chk("l1_read_done", 32'(bw1), 32'd0);
    chk("l1_readdata", rd1, 32'h5A5A_0001);
    chk("l1_read_count", 32'(rc1), 32'd1);
    r1 = 1'b0;
    @(posedge clock); #1;
    chk("l1_idle", 32'(bw1), 32'd0);

    // Write counter saturation, starting near the top
    force dut.wr_cnt_q = 16'hFFFC;
    @(posedge clock); #1;
    release dut.wr_cnt_q;
    @(posedge clock); #1;
    chk("sat_preload", 32'(write_count), 32'h0000_FFFC);
    exp_wr = 16'hFFFC;
    repeat (5) do_write(6'h01, 32'h0000_0001);
    chk("sat_final", 32'(write_count), 32'h0000_FFFF);
    chk("sat_read_count", 32'(read_count), 32'(exp_rd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
